// File: rtl/logic_gate_pipe_if.sv
// Streaming interface for logic_gate_pipe: operand/op input stream and result output stream.
// y_par exists only when LOGIC_GATE_PIPE_PARITY_EN is defined.
interface logic_gate_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] y;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] xfer_cnt;
`ifdef LOGIC_GATE_PIPE_PARITY_EN
    logic             y_par;

    modport slave (
        input  a, b, op, in_valid, out_ready,
        output in_ready, y, out_valid, xfer_cnt, y_par
    );
    modport master (
        output a, b, op, in_valid, out_ready,
        input  in_ready, y, out_valid, xfer_cnt, y_par
    );
`else
    modport slave (
        input  a, b, op, in_valid, out_ready,
        output in_ready, y, out_valid, xfer_cnt
    );
    modport master (
        output a, b, op, in_valid, out_ready,
        input  in_ready, y, out_valid, xfer_cnt
    );
`endif
endinterface

// File: rtl/logic_gate_pipe.sv
// Pipelined bitwise gate unit with valid/ready backpressure and a delivered-result counter.
// Optional result parity output enabled by LOGIC_GATE_PIPE_PARITY_EN.
module logic_gate_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    logic_gate_pipe_if.slave  bus
);
    logic [WIDTH-1:0]  f_res;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] rdy;
    logic [CNT_W-1:0]  cnt_q;
    logic              deliver;

    always_comb begin
        f_res = '0;
        case (bus.op)
            3'b000:  f_res = ~bus.a;
            3'b001:  f_res = bus.a;
            3'b010:  f_res = bus.a & bus.b;
            3'b011:  f_res = bus.a | bus.b;
            3'b100:  f_res = bus.a ^ bus.b;
            3'b101:  f_res = ~(bus.a & bus.b);
            3'b110:  f_res = ~(bus.a | bus.b);
            3'b111:  f_res = ~(bus.a ^ bus.b);
            default: f_res = {WIDTH{1'bx}};
        endcase
    end

    // A stage may load when it is empty or when something downstream frees up this cycle.
    always_comb begin
        logic chain;
        rdy   = '0;
        chain = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            chain  = chain | ~vld_q[k];
            rdy[k] = chain;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            if (rdy[0]) begin
                vld_q[0] <= bus.in_valid;
                if (bus.in_valid) begin
                    data_q[0] <= f_res;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (rdy[k]) begin
                    vld_q[k] <= vld_q[k-1];
                    if (vld_q[k-1]) begin
                        data_q[k] <= data_q[k-1];
                    end
                end
            end
        end
    end

`ifdef LOGIC_GATE_PIPE_PARITY_EN
    logic [STAGES-1:0] par_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= '0;
        end else begin
            if (rdy[0] && bus.in_valid) begin
                par_q[0] <= ^f_res;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (rdy[k] && vld_q[k-1]) begin
                    par_q[k] <= par_q[k-1];
                end
            end
        end
    end

    assign bus.y_par = par_q[STAGES-1];
`endif

    assign deliver = vld_q[STAGES-1] & bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (deliver) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.y         = data_q[STAGES-1];
    assign bus.xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Directed bench for logic_gate_pipe: reset, op sweep, streaming, backpressure, mid-stream reset,
// counter wrap (narrow counter instance) and parity when LOGIC_GATE_PIPE_PARITY_EN is defined.
module tb_logic_gate_pipe;
    logic clk;
    logic rst;
    int   cmp;
    int   err;

    logic_gate_pipe_if #(.WIDTH(8), .CNT_W(16)) bus ();
    logic_gate_pipe_if #(.WIDTH(8), .CNT_W(4))  bus_w ();

    logic_gate_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic_gate_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(4)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (bus_w.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Applies one operation with out_ready high and waits for its result.
    task automatic run_one(input logic [7:0] a_v, input logic [7:0] b_v, input logic [2:0] op_v,
                           output logic [7:0] y_o, output logic par_o, output int lat,
                           output logic rdy_o);
        @(negedge clk);
        bus.a = a_v; bus.b = b_v; bus.op = op_v;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        #1 rdy_o = bus.in_ready;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        y_o = bus.y;
`ifdef LOGIC_GATE_PIPE_PARITY_EN
        par_o = bus.y_par;
`else
        par_o = 1'b0;
`endif
    endtask

    task automatic test_reset;
        #2;
        cmp++; if (bus.out_valid !== 1'b0) begin err++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
        cmp++; if (bus.y !== 8'h00) begin err++; $display("FAIL rst_y: got %h expected 00", bus.y); end
        cmp++; if (bus.xfer_cnt !== 16'd0) begin err++; $display("FAIL rst_cnt: got %0d expected 0", bus.xfer_cnt); end
        cmp++; if (bus_w.xfer_cnt !== 4'd0) begin err++; $display("FAIL rst_cnt_w: got %0d expected 0", bus_w.xfer_cnt); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        cmp++; if (bus.in_ready !== 1'b1) begin err++; $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_op_sweep;
        logic [7:0] exp_tab [8];
        logic [7:0] y_o;
        logic       par_o;
        logic       rdy_o;
        int         lat;
        exp_tab = '{8'h5A, 8'hA5, 8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55};
        for (int op = 0; op < 8; op++) begin
            run_one(8'hA5, 8'h0F, 3'(op), y_o, par_o, lat, rdy_o);
            cmp++; if (rdy_o !== 1'b1) begin err++; $display("FAIL op%0d_in_ready: got %b expected 1", op, rdy_o); end
            cmp++; if (lat != 2) begin err++; $display("FAIL op%0d_latency: got %0d expected 2", op, lat); end
            cmp++; if (y_o !== exp_tab[op]) begin err++; $display("FAIL op%0d_y: got %h expected %h", op, y_o, exp_tab[op]); end
        end
        @(negedge clk);
        cmp++; if (bus.xfer_cnt !== 16'd8) begin err++; $display("FAIL sweep_cnt: got %0d expected 8", bus.xfer_cnt); end
    endtask

    task automatic test_streaming;
        logic [7:0] e;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            bus.op = 3'b000;
            bus.b = 8'h00;
            if (c < 16) begin
                bus.a = 8'(c);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (c < 16) begin
                cmp++; if (bus.in_ready !== 1'b1) begin err++; $display("FAIL stream_in_ready c%0d: got %b expected 1", c, bus.in_ready); end
            end
            cmp++; if (bus.out_valid !== (c >= 2)) begin err++; $display("FAIL stream_valid c%0d: got %b expected %b", c, bus.out_valid, (c >= 2)); end
            if (c >= 2) begin
                e = 8'(c - 2);
                e = ~e;
                cmp++; if (bus.y !== e) begin err++; $display("FAIL stream_y c%0d: got %h expected %h", c, bus.y, e); end
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        cmp++; if (bus.xfer_cnt !== 16'd24) begin err++; $display("FAIL stream_cnt: got %0d expected 24", bus.xfer_cnt); end
    endtask

    task automatic test_backpressure;
        int sent;
        int rcv;
        int cyc;
        logic [7:0] e;
        sent = 0;
        bus.op = 3'b001;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.out_ready = 1'b0;
            bus.in_valid = 1'b1;
            bus.a = 8'(8'h30 + sent);
            #1;
            cmp++; if (bus.in_ready !== (c < 2)) begin err++; $display("FAIL bp_in_ready c%0d: got %b expected %b", c, bus.in_ready, (c < 2)); end
            if (c >= 2) begin
                cmp++; if (bus.out_valid !== 1'b1 || bus.y !== 8'h30) begin err++; $display("FAIL bp_hold c%0d: got v=%b y=%h expected v=1 y=30", c, bus.out_valid, bus.y); end
            end
            if (bus.in_ready) sent++;
        end
        cmp++; if (sent != 2) begin err++; $display("FAIL bp_accepts: got %0d expected 2", sent); end
        rcv = 0;
        cyc = 0;
        while (rcv < 6 && cyc < 30) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            bus.in_valid = (sent < 6);
            bus.a = 8'(8'h30 + sent);
            #1;
            if (bus.out_valid) begin
                e = 8'(8'h30 + rcv);
                cmp++; if (bus.y !== e) begin err++; $display("FAIL bp_order r%0d: got %h expected %h", rcv, bus.y, e); end
                rcv++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            cyc++;
        end
        cmp++; if (rcv != 6) begin err++; $display("FAIL bp_received: got %0d expected 6", rcv); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        cmp++; if (bus.out_valid !== 1'b0) begin err++; $display("FAIL bp_no_dup: got %b expected 0", bus.out_valid); end
        cmp++; if (bus.xfer_cnt !== 16'd30) begin err++; $display("FAIL bp_cnt: got %0d expected 30", bus.xfer_cnt); end
    endtask

    task automatic test_reset_midstream;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.op = 3'b001;
        bus.a = 8'h11;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.a = 8'h22;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        cmp++; if (bus.out_valid !== 1'b1 || bus.y !== 8'h11) begin err++; $display("FAIL mid_inflight: got v=%b y=%h expected v=1 y=11", bus.out_valid, bus.y); end
        rst = 1'b1;
        #1;
        cmp++; if (bus.out_valid !== 1'b0) begin err++; $display("FAIL mid_out_valid: got %b expected 0", bus.out_valid); end
        cmp++; if (bus.y !== 8'h00) begin err++; $display("FAIL mid_y: got %h expected 00", bus.y); end
        cmp++; if (bus.xfer_cnt !== 16'd0) begin err++; $display("FAIL mid_cnt: got %0d expected 0", bus.xfer_cnt); end
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            cmp++; if (bus.out_valid !== 1'b0) begin err++; $display("FAIL mid_stale c%0d: got %b expected 0", c, bus.out_valid); end
        end
    endtask

    task automatic test_counter_wrap;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            bus_w.out_ready = 1'b1;
            bus_w.op = 3'b001;
            bus_w.a = 8'(c);
            bus_w.in_valid = (c < 17);
            #1;
            if (c == 17) begin
                cmp++; if (bus_w.xfer_cnt !== 4'd15) begin err++; $display("FAIL wrap_max: got %0d expected 15", bus_w.xfer_cnt); end
            end
            if (c == 18) begin
                cmp++; if (bus_w.xfer_cnt !== 4'd0) begin err++; $display("FAIL wrap_zero: got %0d expected 0", bus_w.xfer_cnt); end
            end
            if (c == 19) begin
                cmp++; if (bus_w.xfer_cnt !== 4'd1) begin err++; $display("FAIL wrap_17: got %0d expected 1", bus_w.xfer_cnt); end
            end
        end
        bus_w.in_valid = 1'b0;
    endtask

`ifdef LOGIC_GATE_PIPE_PARITY_EN
    task automatic test_parity;
        logic [7:0] y_o;
        logic       par_o;
        logic       rdy_o;
        int         lat;
        run_one(8'h07, 8'h00, 3'b001, y_o, par_o, lat, rdy_o);
        cmp++; if (y_o !== 8'h07 || par_o !== 1'b1) begin err++; $display("FAIL par_07: got y=%h p=%b expected y=07 p=1", y_o, par_o); end
        run_one(8'h03, 8'h00, 3'b001, y_o, par_o, lat, rdy_o);
        cmp++; if (y_o !== 8'h03 || par_o !== 1'b0) begin err++; $display("FAIL par_03: got y=%h p=%b expected y=03 p=0", y_o, par_o); end
        run_one(8'h07, 8'h00, 3'b000, y_o, par_o, lat, rdy_o);
        cmp++; if (y_o !== 8'hF8 || par_o !== 1'b1) begin err++; $display("FAIL par_f8: got y=%h p=%b expected y=F8 p=1", y_o, par_o); end
    endtask
`endif

    initial begin
        cmp = 0;
        err = 0;
        clk = 1'b0;
        rst = 1'b1;
        bus.a = '0; bus.b = '0; bus.op = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus_w.a = '0; bus_w.b = '0; bus_w.op = '0; bus_w.in_valid = 1'b0; bus_w.out_ready = 1'b0;
        test_reset();
        test_op_sweep();
        test_streaming();
        test_backpressure();
        test_reset_midstream();
        test_counter_wrap();
`ifdef LOGIC_GATE_PIPE_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule
